alien_shot_launcher: RTL

//  Consumes the per-pixel bottomAlien/alienType stream from the alien matrix during the VGA scan.

---
 rtl/alien_shot_launcher.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alien_shot_launcher.sv
// Alien shot launcher: picks one bottom-row alien pixel per frame from the scan stream
// and issues a one-cycle missile launch after a randomised frame cooldown.
module alien_shot_launcher #(
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned JITTER_BITS     = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        playGame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        bottomAlien,
  input  logic [1:0]  alienType,
  input  logic        matrixDefeated,
  input  logic        missileActive,
  output logic        launch,
  output logic [10:0] launchX,
  output logic [10:0] launchY,
  output logic [1:0]  launchType,
  output logic        busy
);

  localparam int unsigned CD_W   = 16;
  localparam int unsigned CAND_W = 8;
  localparam int unsigned POS_W  = 11;
  localparam int unsigned TYPE_W = 2;
  localparam logic [CD_W-1:0] CD_BASE  = CD_W'(COOLDOWN_FRAMES);
  localparam logic [15:0]     JIT_MASK = 16'((32'd1 << JITTER_BITS) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_COOLDOWN, S_SEEK, S_FIRE, S_WAIT_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    CD_HOLD, CD_DEC, CD_LD_BASE, CD_LD_JIT
  } cd_op_t;

  state_t state, state_next;
  cd_op_t cd_op;

  logic [15:0]       lfsr;
  logic              bottom_d;
  logic [CD_W-1:0]   cd_cnt;
  logic [CD_W-1:0]   cd_reload;
  logic [CAND_W-1:0] target;
  logic [CAND_W-1:0] cand_cnt;
  logic              first_valid, tgt_valid;
  logic [POS_W-1:0]  first_x, first_y, tgt_x, tgt_y, sel_x, sel_y;
  logic [TYPE_W-1:0] first_type, tgt_type, sel_type;
  logic              seen_active;
  logic [1:0]        wc_frames;
  logic              cand_edge;
  logic              launch_d, seek_entry, scan_capture, sel_latch;

  assign cand_edge = bottomAlien & ~bottom_d;
  assign cd_reload = CD_BASE + CD_W'(lfsr & JIT_MASK);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; playGame=0 overrides matrixDefeated, which overrides everything else
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:       if (playGame) state_next = S_COOLDOWN;
      S_COOLDOWN:   if (startOfFrame && cd_cnt == '0) state_next = S_SEEK;
      S_SEEK:       if (startOfFrame) state_next = (tgt_valid || first_valid) ? S_FIRE : S_COOLDOWN;
      S_FIRE:       if (!missileActive) state_next = S_WAIT_CLEAR;
      S_WAIT_CLEAR: if ((seen_active && !missileActive) ||
                        (!seen_active && startOfFrame && wc_frames == 2'd1))
                      state_next = S_COOLDOWN;
      default:      state_next = S_IDLE;
    endcase
    if (matrixDefeated && state != S_IDLE) state_next = S_COOLDOWN;
    if (!playGame) state_next = S_IDLE;
  end

  // Control strobes derived from the transition being taken
  always_comb begin
    launch_d     = 1'b0;
    seek_entry   = 1'b0;
    scan_capture = 1'b0;
    sel_latch    = 1'b0;
    cd_op        = CD_HOLD;
    launch_d     = (state == S_FIRE) && (state_next == S_WAIT_CLEAR);
    seek_entry   = (state == S_COOLDOWN) && (state_next == S_SEEK);
    scan_capture = (state == S_SEEK) && (state_next == S_SEEK) && !startOfFrame && cand_edge;
    sel_latch    = (state == S_SEEK) && (state_next == S_FIRE);
    if (state_next == S_COOLDOWN) begin
      if (state == S_SEEK && !matrixDefeated)          cd_op = CD_LD_BASE;
      else if (state == S_COOLDOWN && !matrixDefeated) cd_op = startOfFrame ? CD_DEC : CD_HOLD;
      else                                             cd_op = CD_LD_JIT;
    end
  end

  // Datapath: LFSR, cooldown, candidate scan, selection and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr        <= LFSR_SEED;
      bottom_d    <= 1'b0;
      cd_cnt      <= '0;
      target      <= '0;
      cand_cnt    <= '0;
      first_valid <= 1'b0;
      first_x     <= '0;
      first_y     <= '0;
      first_type  <= '0;
      tgt_valid   <= 1'b0;
      tgt_x       <= '0;
      tgt_y       <= '0;
      tgt_type    <= '0;
      sel_x       <= '0;
      sel_y       <= '0;
      sel_type    <= '0;
      seen_active <= 1'b0;
      wc_frames   <= '0;
      launch      <= 1'b0;
      launchX     <= '0;
      launchY     <= '0;
      launchType  <= '0;
      busy        <= 1'b0;
    end else begin
      if (startOfFrame) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      bottom_d <= startOfFrame ? 1'b0 : bottomAlien;

      unique case (cd_op)
        CD_DEC:     cd_cnt <= cd_cnt - CD_W'(1);
        CD_LD_BASE: cd_cnt <= CD_BASE;
        CD_LD_JIT:  cd_cnt <= cd_reload;
        default:    cd_cnt <= cd_cnt;
      endcase

      if (seek_entry) target <= lfsr[11:4];

      if (seek_entry || matrixDefeated) begin
        cand_cnt    <= '0;
        first_valid <= 1'b0;
        tgt_valid   <= 1'b0;
      end else if (scan_capture) begin
        if (!first_valid) begin
          first_valid <= 1'b1;
          first_x     <= pixelX;
          first_y     <= pixelY;
          first_type  <= alienType;
        end
        if (cand_cnt == target) begin
          tgt_valid <= 1'b1;
          tgt_x     <= pixelX;
          tgt_y     <= pixelY;
          tgt_type  <= alienType;
        end
        if (cand_cnt != '1) cand_cnt <= cand_cnt + CAND_W'(1);
      end

      if (sel_latch) begin
        sel_x    <= tgt_valid ? tgt_x    : first_x;
        sel_y    <= tgt_valid ? tgt_y    : first_y;
        sel_type <= tgt_valid ? tgt_type : first_type;
      end

      // Missile-clear tracking with a two-frame timeout if the missile never appears
      if (state != S_WAIT_CLEAR) begin
        seen_active <= 1'b0;
        wc_frames   <= '0;
      end else begin
        seen_active <= seen_active | missileActive;
        if (startOfFrame && !seen_active && wc_frames != 2'd3) wc_frames <= wc_frames + 2'd1;
      end

      launch <= launch_d;
      if (launch_d) begin
        launchX    <= sel_x;
        launchY    <= (sel_y == '1) ? sel_y : sel_y + POS_W'(1);
        launchType <= sel_type;
      end
      busy <= (state_next != S_IDLE);
    end
  end

endmodule
